// File: rtl/adv7513_video_timing_if.sv
// Pixel-fetch and video-output bus between the ADV7513 timing generator and its pixel source /
// transmitter.
interface adv7513_video_timing_if;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pixel_data;
    logic [23:0] vid_d;
    logic        vid_de;
    logic        vid_hs;
    logic        vid_vs;
    logic        frame_start;

    modport master (
        output pix_req, pix_x, pix_y, vid_d, vid_de, vid_hs, vid_vs, frame_start,
        input  pixel_data
    );

    modport slave (
        input  pix_req, pix_x, pix_y, vid_d, vid_de, vid_hs, vid_vs, frame_start,
        output pixel_data
    );
endinterface

// File: rtl/adv7513_video_timing.sv
// Raster timing generator for the ADV7513: counters, pixel fetch requests and a registered
// RGB/DE/sync bus with an optional 8-bar colour pattern.
module adv7513_video_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   test_mode,
    output logic                   running,
    adv7513_video_timing_if.master vid
);
    localparam logic [9:0] HActive  = 10'(H_ACTIVE);
    localparam logic [9:0] HSyncBeg = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] HLast    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VActive  = 10'(V_ACTIVE);
    localparam logic [9:0] VSyncBeg = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] VLast    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        cnt_en, active, hs_raw, vs_raw, line_end, frame_end;
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    logic        pix_req_q, pix_req_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        al_de_q, al_de_d, al_hs_q, al_hs_d, al_vs_q, al_vs_d;
    logic        al_first_q, al_first_d, al_tm_q, al_tm_d;
    logic [23:0] al_bar_q, al_bar_d;
    logic        out_de_q, out_de_d, out_hs_q, out_hs_d, out_vs_q, out_vs_d;
    logic        out_fs_q, out_fs_d;
    logic [23:0] out_d_q, out_d_d;

    assign line_end  = (h_cnt_q == HLast);
    assign frame_end = line_end && (v_cnt_q == VLast);

    // The IDLE clock that sees enable already presents pixel (0,0), so the request
    // pipeline starts in the same clock the state enters RUN.
    always_comb begin
        state_d = StIdle;
        cnt_en  = 1'b0;
        h_cnt_d = '0;
        v_cnt_d = '0;
        case (state_q)
            StIdle: begin
                cnt_en  = enable;
                state_d = enable ? StRun : StIdle;
            end
            StRun: begin
                cnt_en  = 1'b1;
                state_d = enable ? StRun : StDrain;
            end
            StDrain: begin
                cnt_en  = 1'b1;
                state_d = enable ? StRun : (frame_end ? StIdle : StDrain);
            end
            default: ;
        endcase
        if (cnt_en) begin
            h_cnt_d = line_end ? '0 : h_cnt_q + 10'd1;
            v_cnt_d = v_cnt_q;
            if (line_end) v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
        end
    end

    assign active = cnt_en && (h_cnt_q < HActive) && (v_cnt_q < VActive);
    assign hs_raw = (h_cnt_q >= HSyncBeg) && (h_cnt_q < HSyncEnd);
    assign vs_raw = (v_cnt_q >= VSyncBeg) && (v_cnt_q < VSyncEnd);

    assign bar_idx = 3'(({22'd0, pix_x_q} * 32'd8) / H_ACTIVE);

    always_comb begin
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    // Middle stage holds timing while the source returns pixel_data one clock after pix_req.
    always_comb begin
        pix_req_d  = active;
        pix_x_d    = h_cnt_q;
        pix_y_d    = v_cnt_q;
        hs1_d      = hs_raw;
        vs1_d      = vs_raw;
        al_de_d    = pix_req_q;
        al_hs_d    = hs1_q;
        al_vs_d    = vs1_q;
        al_first_d = pix_req_q && (pix_x_q == '0) && (pix_y_q == '0);
        al_tm_d    = test_mode;
        al_bar_d   = bar_rgb;
        out_de_d   = al_de_q;
        out_hs_d   = al_hs_q;
        out_vs_d   = al_vs_q;
        out_fs_d   = al_first_q;
        out_d_d    = !al_de_q ? 24'h000000 : (al_tm_q ? al_bar_q : vid.pixel_data);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            pix_req_q  <= 1'b0;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            al_de_q    <= 1'b0;
            al_hs_q    <= 1'b0;
            al_vs_q    <= 1'b0;
            al_first_q <= 1'b0;
            al_tm_q    <= 1'b0;
            al_bar_q   <= '0;
            out_de_q   <= 1'b0;
            out_hs_q   <= 1'b0;
            out_vs_q   <= 1'b0;
            out_fs_q   <= 1'b0;
            out_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            pix_req_q  <= pix_req_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            al_de_q    <= al_de_d;
            al_hs_q    <= al_hs_d;
            al_vs_q    <= al_vs_d;
            al_first_q <= al_first_d;
            al_tm_q    <= al_tm_d;
            al_bar_q   <= al_bar_d;
            out_de_q   <= out_de_d;
            out_hs_q   <= out_hs_d;
            out_vs_q   <= out_vs_d;
            out_fs_q   <= out_fs_d;
            out_d_q    <= out_d_d;
        end
    end

    assign running         = (state_q == StRun);
    assign vid.pix_req     = pix_req_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.vid_de      = out_de_q;
    assign vid.vid_hs      = ~(out_hs_q ^ HS_POL);
    assign vid.vid_vs      = ~(out_vs_q ^ VS_POL);
    assign vid.frame_start = out_fs_q;
    assign vid.vid_d       = out_d_q;
endmodule

// File: tb/tb_adv7513_video_timing.sv
// Scoreboard bench for adv7513_video_timing on a reduced raster (80x19 clocks, 64x12 active).
module tb_adv7513_video_timing;
    localparam int unsigned HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int unsigned VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int FRAME = 1520;  // 80 * 19

    typedef struct packed {
        logic [23:0] d;
        logic [9:0]  x;
        logic [9:0]  y;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic test_mode = 1'b0;
    logic running;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic [23:0] pend = '0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    adv7513_video_timing_if vif ();

    adv7513_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .test_mode(test_mode),
        .running  (running),
        .vid      (vif)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Pixel source: answers each request one clock later and records what must come out.
    always @(negedge clk) begin
        exp_t e;
        vif.pixel_data = pend;
        pend = {vif.pix_x[7:0], vif.pix_y[7:0], 8'hA5};
        if (vif.pix_req === 1'b1) begin
            e.x = vif.pix_x;
            e.y = vif.pix_y;
            e.d = test_mode ? bars[vif.pix_x[5:3]] : {vif.pix_x[7:0], vif.pix_y[7:0], 8'hA5};
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (vif.vid_de === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: vid_de with no pending pixel, vid_d %06h", vif.vid_d);
            end else begin
                e = sb_q.pop_front();
                check("vid_d", vif.vid_d, e.d);
                check("frame_start", vif.frame_start, (e.x == 0) && (e.y == 0));
            end
        end else begin
            check("vid_d_blank", vif.vid_d, 0);
            check("frame_start_blank", vif.frame_start, 0);
        end
    end

    task automatic check_reset_vals(string tag);
        check({tag, "_pix_req"}, vif.pix_req, 0);
        check({tag, "_pix_x"}, vif.pix_x, 0);
        check({tag, "_pix_y"}, vif.pix_y, 0);
        check({tag, "_vid_d"}, vif.vid_d, 0);
        check({tag, "_vid_de"}, vif.vid_de, 0);
        check({tag, "_vid_hs"}, vif.vid_hs, 1);
        check({tag, "_vid_vs"}, vif.vid_vs, 1);
        check({tag, "_frame_start"}, vif.frame_start, 0);
        check({tag, "_running"}, running, 0);
    endtask

    task automatic wait_pix(input int x, input int y);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(vif.pix_req === 1'b1 && vif.pix_x == x && vif.pix_y == y) && guard < 2 * FRAME);
        check("wait_pix", guard < 2 * FRAME, 1);
    endtask

    task automatic measure_line();
        int guard = 0;
        int de_n = 0, hs_n = 0, hs_start = -1;
        while (vif.vid_de !== 1'b0 && guard < 2 * FRAME) begin @(negedge clk); guard++; end
        while (vif.vid_de !== 1'b1 && guard < 2 * FRAME) begin @(negedge clk); guard++; end
        check("line_wait", guard < 2 * FRAME, 1);
        for (int i = 0; i < 80; i++) begin
            if (vif.vid_de) de_n++;
            if (!vif.vid_hs) begin
                hs_n++;
                if (hs_start < 0) hs_start = i;
            end
            @(negedge clk);
        end
        check("line_de_clocks", de_n, 64);
        check("line_hs_start", hs_start, 68);
        check("line_hs_width", hs_n, 8);
    endtask

    task automatic measure_frame();
        int guard = 0;
        int de_n = 0, de_lines = 0, vs_n = 0, vs_start = -1, fs_extra = 0;
        logic de_prev = 1'b0;
        while (vif.frame_start !== 1'b1 && guard < 2 * FRAME) begin @(negedge clk); guard++; end
        check("frame_wait", guard < 2 * FRAME, 1);
        for (int i = 0; i < FRAME; i++) begin
            if (vif.vid_de) de_n++;
            if (vif.vid_de && !de_prev) de_lines++;
            de_prev = vif.vid_de;
            if (!vif.vid_vs) begin
                vs_n++;
                if (vs_start < 0) vs_start = i;
            end
            if (i > 0 && vif.frame_start) fs_extra++;
            @(negedge clk);
        end
        check("frame_de_clocks", de_n, 768);
        check("frame_de_lines", de_lines, 12);
        check("frame_vs_clocks", vs_n, 160);
        check("frame_vs_start", vs_start, 1120);
        check("frame_start_extra", fs_extra, 0);
        check("frame_start_period", vif.frame_start, 1);
    endtask

    initial begin
        int de_cnt, run_hi;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");

        reset = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("c1_running", running, 1);
        check("c1_pix_req", vif.pix_req, 1);
        check("c1_pix_x", vif.pix_x, 0);
        check("c1_pix_y", vif.pix_y, 0);
        check("c1_vid_de", vif.vid_de, 0);
        @(negedge clk);
        check("c2_vid_de", vif.vid_de, 0);
        @(negedge clk);
        check("c3_vid_de", vif.vid_de, 1);
        check("c3_frame_start", vif.frame_start, 1);

        measure_line();
        measure_frame();

        @(posedge clk);
        #2 test_mode = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        @(posedge clk);
        #2 test_mode = 1'b0;

        wait_pix(0, 5);
        @(posedge clk);
        #2 enable = 1'b0;
        de_cnt = 0;
        run_hi = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (vif.vid_de) de_cnt++;
            if (running) run_hi++;
        end
        check("drain_de_clocks", de_cnt, 7 * 64);
        check("drain_running_samples", run_hi, 1);
        check("idle_pix_req", vif.pix_req, 0);
        check("idle_vid_de", vif.vid_de, 0);
        check("idle_vid_hs", vif.vid_hs, 1);
        check("idle_vid_vs", vif.vid_vs, 1);
        check("idle_sb_empty", sb_q.size(), 0);

        @(posedge clk);
        #2 enable = 1'b1;
        wait_pix(20, 7);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        sb_q.delete();
        enable = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_pix_req", vif.pix_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
